// File: rtl/avalon_mm_ram_slave_if.sv
// ---------------------------------------------------------------------------
// avalon_mm_ram_slave_if
// Avalon-MM bus bundle between a master-side block and avalon_mm_ram_slave.
//
// Signals:
//   address        word address (not a byte address)
//   read / write   single-beat requests
//   writedata      write payload
//   readdata       read response payload
//   readdatavalid  qualifies readdata for exactly one cycle per accepted read
//
// Handshake: there is no waitrequest. A beat with read or write high at a
// rising clock edge is accepted at that edge unconditionally. Each accepted
// read produces exactly one readdatavalid pulse, in request order, a fixed
// number of cycles later. readdata is meaningful only while readdatavalid=1.
// ---------------------------------------------------------------------------
interface avalon_mm_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_ram_slave.sv
// ---------------------------------------------------------------------------
// avalon_mm_ram_slave
// Avalon-MM responder backed by an internal word-addressed RAM. Accepts one
// read or write per cycle with no wait states and returns read data a fixed
// READ_LATENCY cycles after the accept edge, qualified by readdatavalid.
// Out-of-range accesses and simultaneous read+write are flagged in
// err_count; reads of that kind return ERR_VALUE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        slave modport: address, read, write, writedata,
//              readdata, readdatavalid
//   rd_count   accepted reads, saturating
//   wr_count   committed (in-range) writes, saturating
//   err_count  out-of-range or illegal accesses, saturating
//
// Parameter legality: DEPTH_LOG2 <= ADDR_WIDTH, READ_LATENCY in 1..4.
// ---------------------------------------------------------------------------
module avalon_mm_ram_slave #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DEPTH_LOG2   = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ERR_VALUE    = 32'hDEAD_BEEF,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  avalon_mm_ram_slave_if.slave bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_VALUE);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [DEPTH_LOG2-1:0] index;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  rd_inc;
  logic                  wr_inc;
  logic                  err_inc;

  // Read pipeline: entry 0 is loaded at the accept edge, the output stage
  // picks up the last entry, giving exactly READ_LATENCY edges to the pulse.
  logic                  pipe_v [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];

  assign in_range = (bus.address >> DEPTH_LOG2) == '0;
  assign index    = bus.address[DEPTH_LOG2-1:0];

  // A read that coincides with a write is illegal and always answers
  // ERR_VALUE, so it never needs the same-edge write data.
  assign rd_ok   = bus.read && !bus.write && in_range;
  assign rd_inc  = bus.read;
  assign wr_inc  = bus.write && in_range;
  assign err_inc = (bus.write && !in_range) ||
                   (bus.read && (!in_range || bus.write));

  // The RAM word is resolved at the accept edge and carried down the
  // pipeline, so writes landing while the read is in flight cannot alter
  // its response. Writes from earlier edges are already in mem here.
  always_comb begin
    rd_value = ERR_DATA;
    if (rd_ok) rd_value = mem[index];
  end

  // RAM array has no reset: contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_inc) mem[index] <= bus.writedata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
      bus.readdatavalid <= 1'b0;
      bus.readdata      <= '0;
    end else begin
      pipe_v[0] <= bus.read;
      pipe_d[0] <= rd_value;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      bus.readdatavalid <= pipe_v[READ_LATENCY-1];
      // readdata holds its previous value on cycles without a response.
      if (pipe_v[READ_LATENCY-1]) bus.readdata <= pipe_d[READ_LATENCY-1];
    end
  end

  // Saturating counters: each stops at all-ones and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (rd_inc  && rd_count  != '1) rd_count  <= rd_count  + CNT_ONE;
      if (wr_inc  && wr_count  != '1) wr_count  <= wr_count  + CNT_ONE;
      if (err_inc && err_count != '1) err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_avalon_mm_ram_slave.sv
module tb_avalon_mm_ram_slave;

  localparam int          RL      = 2;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  avalon_mm_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  avalon_mm_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  logic [15:0] rd_count, wr_count, err_count;
  logic [3:0]  rd_count2, wr_count2, err_count2;

  avalon_mm_ram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(8),
    .READ_LATENCY(RL), .ERR_VALUE(ERR_VAL), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  avalon_mm_ram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(8),
    .READ_LATENCY(RL), .ERR_VALUE(ERR_VAL), .CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .rd_count(rd_count2), .wr_count(wr_count2), .err_count(err_count2)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem_m   [256];
  bit          known_m [256];
  logic [31:0] exp_q [$];   // expected read responses, in order
  int          due_q [$];   // cycle on which each response must appear
  logic [31:0] last_data;
  int          rd_m, wr_m, err_m;
  int          cyc;

  int n_checks;
  int n_err;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    last_data = '0;
    rd_m = 0;
    wr_m = 0;
    err_m = 0;
  endtask

  // Compare all DUT outputs against the model for the current cycle.
  task automatic compare_outputs();
    logic exp_v;
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    if (exp_v) begin
      last_data = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    check("readdatavalid", 32'(bus.readdatavalid), 32'(exp_v));
    check("readdata", bus.readdata, last_data);
    check("rd_count", 32'(rd_count), 32'(sat16(rd_m)));
    check("wr_count", 32'(wr_count), 32'(sat16(wr_m)));
    check("err_count", 32'(err_count), 32'(sat16(err_m)));
  endtask

  // ---------------- driver ----------------
  // One bus beat: drive, let the model predict the edge, clock, then compare.
  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data);
    logic        ok;
    logic [31:0] rv;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = addr;
    bus.writedata = data;
    ok = (addr < 32'd256);
    if (rd) begin
      if (wr || !ok) rv = ERR_VAL;
      else rv = mem_m[addr[7:0]];
      exp_q.push_back(rv);
      due_q.push_back(cyc + 1 + RL);
      rd_m++;
      if (wr || !ok) err_m++;
    end else if (wr && !ok) begin
      err_m++;
    end
    if (wr && ok) begin
      mem_m[addr[7:0]]   = data;
      known_m[addr[7:0]] = 1'b1;
      wr_m++;
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    for (int i = 0; i < 256; i++) known_m[i] = 1'b0;
    model_reset();
    bus.read = 1'b0;  bus.write = 1'b0;  bus.address = '0;  bus.writedata = '0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = '0; bus2.writedata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;

    // Basic write then read of the same word
    step(1'b0, 1'b1, 32'd5, 32'h1234_5678);
    step(1'b1, 1'b0, 32'd5, 32'h0);
    idle(RL + 1);

    // Back-to-back writes then back-to-back reads
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i), 32'(i * 3));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i), 32'h0);
    idle(RL + 1);

    // Out of range write and read, RAM[0] must be untouched
    step(1'b0, 1'b1, 32'h100, 32'h0000_AAAA);
    step(1'b1, 1'b0, 32'h100, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    idle(RL + 1);

    // Illegal simultaneous read+write, then read the written word
    step(1'b1, 1'b1, 32'd7, 32'h55);
    step(1'b1, 1'b0, 32'd7, 32'h0);
    idle(RL + 1);

    // Randomized mix against the model
    for (int i = 0; i < 300; i++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
      else a = 32'($urandom_range(0, 255));
      if (op < 2) begin
        step(1'b0, 1'b0, $urandom, $urandom);
      end else if (op < 5) begin
        step(1'b0, 1'b1, a, $urandom);
      end else if (op < 9) begin
        if (a < 32'd256 && !known_m[a[7:0]]) a = 32'd5;
        step(1'b1, 1'b0, a, $urandom);
      end else begin
        step(1'b1, 1'b1, a, $urandom);
      end
    end
    idle(RL + 1);

    // Reset with reads in flight
    step(1'b1, 1'b0, 32'd5, 32'h0);
    step(1'b1, 1'b0, 32'd6, 32'h0);
    step(1'b1, 1'b0, 32'd7, 32'h0);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      compare_outputs();
    end
    rst_n = 1'b1;
    idle(RL + 2);
    step(1'b1, 1'b0, 32'd7, 32'h0);
    idle(RL + 1);

    // Counter saturation on the narrow-counter instance
    for (int i = 0; i < 20; i++) begin
      bus2.write     = 1'b1;
      bus2.address   = 32'(i);
      bus2.writedata = $urandom;
      @(posedge clk);
      #1;
      bus2.write = 1'b0;
      check("sat_wr_count", 32'(wr_count2), 32'((i + 1 > 15) ? 15 : i + 1));
    end
    repeat (3) @(posedge clk);
    #1;
    check("sat_wr_hold", 32'(wr_count2), 32'd15);
    check("sat_rd_count", 32'(rd_count2), 32'd0);
    check("sat_err_count", 32'(err_count2), 32'd0);

    // Report
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $error("FAIL pending_responses observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
